bist_ctrl_tdr: RTL and testbench
================================

Name: bist_ctrl_tdr

Overview:
- Test data register that sits directly downstream of the wrapper/TAP controller.
- Consumes the controller's CaptureDR/ShiftDR/UpdateDR strobes and its decoded enable, and turns shifted commands into a start/busy/done handshake with a memory BIST engine.
- Captures BIST status back into the serial path.
- Intended to occupy a decoded TDR slot (EN line) and feed the WSO mux.

Parameters:
- TIMEOUT_W, 16: width of the per-run watchdog counter; timeout fires at 2^TIMEOUT_W-1 cycles.
- DR_W, 20 (localparam, not overridable): serial register length.

Ports:
- TCLK  in  1  test clock; all state on posedge.
- TRESET  in  1  asynchronous, active-high reset.
- CaptureDR  in  1  capture strobe from controller.
- ShiftDR  in  1  shift strobe from controller.
- UpdateDR  in  1  update strobe from controller.
- Enable  in  1  instruction decode select for this TDR.
- SI  in  1  serial in (WSI).
- SO  out  1  serial out, equals sr[0] (combinational).
- BIST_START  out  1  run request, level.
- BIST_ABORT  out  1  one-cycle abort pulse to engine.
- BIST_ALGO  out  2  algorithm select, stable while busy.
- BIST_BUSY  in  1  engine acknowledges start / running.
- BIST_DONE  in  1  one-cycle end-of-run pulse.
- BIST_FAIL  in  1  run result, valid when BIST_DONE=1.

Behaviour:
- Reset values: sr=0, SO=0, BIST_START=0, BIST_ABORT=0, BIST_ALGO=0, state=IDLE, all status bits and counters 0.
- Shift register sr[19:0] is active only when Enable=1. Priority is CaptureDR > ShiftDR > hold.
  - Capture: sr <= status word.
  - Shift: sr <= {SI, sr[19:1]}.
- Update field layout, latched from sr when UpdateDR=1 and Enable=1:
  - [0] START
  - [1] ABORT
  - [3:2] ALGO
  - [11:4] LOOPS (0 is treated as 1)
  - [19:12] ignored
- Capture status layout:
  - [0] BUSY (state!=IDLE)
  - [1] DONE
  - [2] FAIL (sticky OR of BIST_FAIL)
  - [3] TIMEOUT
  - [4] CMD_ERR
  - [5] ABORTED
  - [7:6] BIST_ALGO
  - [15:8] RUNS_DONE
  - [19:16] FAIL_COUNT (see optional feature)
- FSM states: IDLE, LAUNCH, RUN.
- IDLE:
  - Update with ABORT=1 is a no-op, and any START in the same word is ignored.
  - Update with START=1, ABORT=0:
    - load ALGO and LOOPS;
    - clear DONE, FAIL, TIMEOUT, CMD_ERR, ABORTED, RUNS_DONE, FAIL_COUNT;
    - go to LAUNCH.
- LAUNCH:
  - BIST_START=1 (registered, asserted the cycle after the update).
  - On BIST_BUSY=1: drop BIST_START next cycle, go to RUN.
- RUN: on BIST_DONE=1:
  - RUNS_DONE++ and FAIL |= BIST_FAIL.
  - If RUNS_DONE+1 == max(LOOPS,1): go to IDLE, set DONE.
  - Otherwise go back to LAUNCH.
- Watchdog:
  - Counter cleared on every entry into LAUNCH or RUN; increments each cycle in those states.
  - At all-ones: TIMEOUT=1, DONE=1, one-cycle BIST_ABORT, BIST_START=0, go to IDLE.
  - BIST_DONE in the same cycle as expiry: DONE handling wins and no timeout is recorded.
- Update while not IDLE:
  - ABORT=1: one-cycle BIST_ABORT, ABORTED=1, DONE=1, BIST_START=0, go to IDLE. ABORT has priority over START.
  - START=1 with ABORT=0: ignored, CMD_ERR=1. ALGO and LOOPS are unchanged.
- Counter width rules: RUNS_DONE is 8-bit and cannot wrap, because LOOPS is ≤255. Loop-count compare is 8-bit.
- BIST_DONE or BIST_BUSY arriving in IDLE: ignored.
- TRESET mid-run: immediate return to reset values. BIST_START deasserts asynchronously; no abort pulse is generated.
- Enable=0: strobes ignored, sr holds. The FSM keeps running independently of Enable.

Optional Feature:
- Macro BIST_CTRL_TDR_FAIL_COUNT_EN.
- When defined: a 4-bit saturating counter increments on each BIST_DONE with BIST_FAIL=1, stops at 15, and is captured into [19:16].
- When undefined: no counter is built and [19:16] capture as 0.

Test Plan:
- Reset, then capture and shift 20 bits → SO stream all 0. Reset of BIST_START=0 checked while TRESET high.
- Shift update word START=1, ALGO=2, LOOPS=3; engine acks BUSY after 2 cycles, DONE after 10, FAIL=0/1/0 → BIST_START pulses 3 times, BIST_ALGO=2. Capture gives DONE=1, FAIL=1, RUNS_DONE=3, BUSY=0, FAIL_COUNT=1 with the macro, 0 without.
- LOOPS=0, START=1 → exactly one run; capture RUNS_DONE=1.
- TIMEOUT_W=4, engine never asserts BUSY → BIST_START high 15 cycles, one BIST_ABORT pulse, capture TIMEOUT=1, DONE=1, BUSY=0.
- Mid-run: START=1 update gives CMD_ERR=1 with the run continuing. Then ABORT=1 update gives a one-cycle BIST_ABORT; capture ABORTED=1, DONE=1.
- BIST_DONE coincident with watchdog expiry → TIMEOUT=0, RUNS_DONE increments. Separately, assert TRESET during RUN → all outputs return to 0 immediately.

Source files
------------

// File: rtl/bist_ctrl_tdr.sv
// rtl/bist_ctrl_tdr.sv - BIST control test data register with start/busy/done handshake and run watchdog.
// Optional macro BIST_CTRL_TDR_FAIL_COUNT_EN adds a saturating failing-run counter to capture bits [19:16].
module bist_ctrl_tdr #(
    parameter int TIMEOUT_W = 16
) (
    input  logic       TCLK,
    input  logic       TRESET,
    input  logic       CaptureDR,
    input  logic       ShiftDR,
    input  logic       UpdateDR,
    input  logic       Enable,
    input  logic       SI,
    output logic       SO,
    output logic       BIST_START,
    output logic       BIST_ABORT,
    output logic [1:0] BIST_ALGO,
    input  logic       BIST_BUSY,
    input  logic       BIST_DONE,
    input  logic       BIST_FAIL
);

    localparam int DR_W = 20;
    localparam logic [TIMEOUT_W-1:0] WD_ONE = TIMEOUT_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [DR_W-1:0]      sr_q, sr_d;
    logic                 start_q, start_d;
    logic                 abort_q, abort_d;
    logic [1:0]           algo_q, algo_d;
    logic [7:0]           loops_q, loops_d;
    logic [7:0]           runs_q, runs_d;
    logic                 done_q, done_d;
    logic                 fail_q, fail_d;
    logic                 timeout_q, timeout_d;
    logic                 cmd_err_q, cmd_err_d;
    logic                 aborted_q, aborted_d;
    logic [TIMEOUT_W-1:0] wd_q, wd_d;

    logic                 upd;
    logic                 cmd_start;
    logic                 cmd_abort;
    logic [1:0]           cmd_algo;
    logic [7:0]           cmd_loops;
    logic                 launch_req;
    logic                 abort_req;
    logic                 done_ev;
    logic [7:0]           loops_eff;
    logic [7:0]           runs_inc;
    logic [TIMEOUT_W-1:0] wd_inc;
    logic                 wd_expire;
    logic [3:0]           fail_cnt;
    logic [DR_W-1:0]      status;

    assign upd       = UpdateDR & Enable;
    assign cmd_start = sr_q[0];
    assign cmd_abort = sr_q[1];
    assign cmd_algo  = sr_q[3:2];
    assign cmd_loops = sr_q[11:4];

    assign launch_req = upd & cmd_start & ~cmd_abort & (state_q == IDLE);
    assign abort_req  = upd & cmd_abort & (state_q != IDLE);
    assign done_ev    = (state_q == RUN) & BIST_DONE & ~abort_req;

    // A loop count of zero still performs one run.
    assign loops_eff = (loops_q == 8'd0) ? 8'd1 : loops_q;
    assign runs_inc  = runs_q + 8'd1;
    // Expiry lands on the (2^TIMEOUT_W - 1)-th cycle spent in LAUNCH/RUN.
    assign wd_inc    = wd_q + WD_ONE;
    assign wd_expire = &wd_inc;

    assign status = {fail_cnt, runs_q, algo_q, aborted_q, cmd_err_q,
                     timeout_q, fail_q, done_q, (state_q != IDLE)};

    assign SO         = sr_q[0];
    assign BIST_START = start_q;
    assign BIST_ABORT = abort_q;
    assign BIST_ALGO  = algo_q;

    always_comb begin
        sr_d = sr_q;
        if (Enable) begin
            if (CaptureDR) begin
                sr_d = status;
            end else if (ShiftDR) begin
                sr_d = {SI, sr_q[DR_W-1:1]};
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        abort_d   = 1'b0;
        algo_d    = algo_q;
        loops_d   = loops_q;
        runs_d    = runs_q;
        done_d    = done_q;
        fail_d    = fail_q;
        timeout_d = timeout_q;
        cmd_err_d = cmd_err_q;
        aborted_d = aborted_q;

        case (state_q)
            IDLE: begin
                if (launch_req) begin
                    algo_d    = cmd_algo;
                    loops_d   = cmd_loops;
                    runs_d    = 8'd0;
                    done_d    = 1'b0;
                    fail_d    = 1'b0;
                    timeout_d = 1'b0;
                    cmd_err_d = 1'b0;
                    aborted_d = 1'b0;
                    state_d   = LAUNCH;
                end
            end
            LAUNCH, RUN: begin
                if (abort_req) begin
                    abort_d   = 1'b1;
                    aborted_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end else begin
                    if (upd && cmd_start) begin
                        cmd_err_d = 1'b1;
                    end
                    // An end-of-run pulse beats a watchdog expiry in the same cycle.
                    if (done_ev) begin
                        runs_d = runs_inc;
                        fail_d = fail_q | BIST_FAIL;
                        if (runs_inc == loops_eff) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = LAUNCH;
                        end
                    end else if (wd_expire) begin
                        timeout_d = 1'b1;
                        done_d    = 1'b1;
                        abort_d   = 1'b1;
                        state_d   = IDLE;
                    end else if (state_q == LAUNCH && BIST_BUSY) begin
                        state_d = RUN;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        wd_d = wd_q;
        if (state_d != IDLE && state_d != state_q) begin
            wd_d = '0;
        end else if (state_q != IDLE) begin
            wd_d = wd_inc;
        end
    end

    assign start_d = (state_d == LAUNCH);

    always_ff @(posedge TCLK or posedge TRESET) begin
        if (TRESET) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            start_q   <= 1'b0;
            abort_q   <= 1'b0;
            algo_q    <= 2'd0;
            loops_q   <= 8'd0;
            runs_q    <= 8'd0;
            done_q    <= 1'b0;
            fail_q    <= 1'b0;
            timeout_q <= 1'b0;
            cmd_err_q <= 1'b0;
            aborted_q <= 1'b0;
            wd_q      <= '0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            start_q   <= start_d;
            abort_q   <= abort_d;
            algo_q    <= algo_d;
            loops_q   <= loops_d;
            runs_q    <= runs_d;
            done_q    <= done_d;
            fail_q    <= fail_d;
            timeout_q <= timeout_d;
            cmd_err_q <= cmd_err_d;
            aborted_q <= aborted_d;
            wd_q      <= wd_d;
        end
    end

`ifdef BIST_CTRL_TDR_FAIL_COUNT_EN
    logic [3:0] fail_cnt_q, fail_cnt_d;

    always_comb begin
        fail_cnt_d = fail_cnt_q;
        if (launch_req) begin
            fail_cnt_d = 4'd0;
        end else if (done_ev && BIST_FAIL && fail_cnt_q != 4'hF) begin
            fail_cnt_d = fail_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge TCLK or posedge TRESET) begin
        if (TRESET) begin
            fail_cnt_q <= 4'd0;
        end else begin
            fail_cnt_q <= fail_cnt_d;
        end
    end

    assign fail_cnt = fail_cnt_q;
`else
    assign fail_cnt = 4'd0;
`endif

endmodule

// File: tb/tb_bist_ctrl_tdr.sv
// tb/tb_bist_ctrl_tdr.sv - Scoreboard bench for bist_ctrl_tdr with a behavioural BIST engine.
module tb_bist_ctrl_tdr;

    logic       TCLK = 1'b0;
    logic       TRESET;
    logic       CaptureDR, ShiftDR, UpdateDR, Enable, SI;
    logic       SO, BIST_START, BIST_ABORT;
    logic [1:0] BIST_ALGO;
    logic       BIST_BUSY, BIST_DONE, BIST_FAIL;

    int checks = 0;
    int errors = 0;

    logic [19:0] exp_q[$];
    logic [19:0] msk_q[$];
    string       nm_q[$];

    // Engine configuration, written only by the stimulus process.
    bit          eng_en = 1'b1;
    int          busy_delay = 2;
    int          done_delay = 10;
    logic [15:0] fail_pat = '0;
    int          eng_base = 0;

    // Engine and monitor state, written only by their own processes.
    int eng_st = 0;
    int eng_cnt = 0;
    int eng_runs = 0;
    int mon_start_high = 0;
    int mon_start_rises = 0;
    int mon_abort = 0;
    logic mon_prev_start = 1'b0;

`ifdef BIST_CTRL_TDR_FAIL_COUNT_EN
    localparam logic [3:0] FC1 = 4'd1;
`else
    localparam logic [3:0] FC1 = 4'd0;
`endif

    bist_ctrl_tdr #(.TIMEOUT_W(4)) dut (
        .TCLK(TCLK), .TRESET(TRESET), .CaptureDR(CaptureDR), .ShiftDR(ShiftDR),
        .UpdateDR(UpdateDR), .Enable(Enable), .SI(SI), .SO(SO),
        .BIST_START(BIST_START), .BIST_ABORT(BIST_ABORT), .BIST_ALGO(BIST_ALGO),
        .BIST_BUSY(BIST_BUSY), .BIST_DONE(BIST_DONE), .BIST_FAIL(BIST_FAIL)
    );

    always #5 TCLK = ~TCLK;

    always @(negedge TCLK) begin
        if (TRESET || BIST_ABORT) begin
            eng_st = 0;
            BIST_BUSY = 1'b0;
            BIST_DONE = 1'b0;
            BIST_FAIL = 1'b0;
        end else begin
            case (eng_st)
                0: if (eng_en && BIST_START) begin eng_st = 1; eng_cnt = 0; end
                1: begin
                    eng_cnt++;
                    if (eng_cnt == busy_delay) begin BIST_BUSY = 1'b1; eng_st = 2; eng_cnt = 0; end
                end
                2: begin
                    eng_cnt++;
                    if (eng_cnt == done_delay) begin
                        BIST_DONE = 1'b1;
                        BIST_FAIL = fail_pat[4'(eng_runs - eng_base)];
                        eng_runs++;
                        eng_st = 3;
                    end
                end
                default: begin
                    BIST_DONE = 1'b0;
                    BIST_FAIL = 1'b0;
                    BIST_BUSY = 1'b0;
                    eng_st = 0;
                end
            endcase
        end
    end

    always @(negedge TCLK) begin
        if (BIST_START) mon_start_high++;
        if (BIST_START && !mon_prev_start) mon_start_rises++;
        if (BIST_ABORT) mon_abort++;
        mon_prev_start = BIST_START;
    end

    function automatic logic [19:0] cmd(input logic start, input logic abort,
                                        input logic [1:0] algo, input logic [7:0] loops);
        return {8'h00, loops, algo, abort, start};
    endfunction

    task automatic push_exp(input string nm, input logic [19:0] e, input logic [19:0] m);
        nm_q.push_back(nm);
        exp_q.push_back(e);
        msk_q.push_back(m);
    endtask

    // Capture, shift 20 bits out while shifting din in, then update.
    task automatic scan(input logic [19:0] din, input bit chk);
        logic [19:0] so_word;
        logic [19:0] e, m;
        string nm;
        @(negedge TCLK); Enable = 1'b1; CaptureDR = 1'b1;
        @(negedge TCLK); CaptureDR = 1'b0; ShiftDR = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge TCLK);
            so_word[i] = SO;
            SI = din[i];
        end
        @(negedge TCLK); ShiftDR = 1'b0; UpdateDR = 1'b1; SI = 1'b0;
        @(negedge TCLK); UpdateDR = 1'b0;
        if (chk) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty: got %h expected a queued entry", so_word);
            end else begin
                e = exp_q.pop_front(); m = msk_q.pop_front(); nm = nm_q.pop_front();
                if ((so_word & m) !== (e & m)) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h mask %h", nm, so_word, e, m);
                end
            end
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge TCLK);
    endtask

    task automatic check_int(input string nm, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, want);
        end
    endtask

    task automatic test_reset();
        TRESET = 1'b1; CaptureDR = 1'b0; ShiftDR = 1'b0; UpdateDR = 1'b0;
        Enable = 1'b0; SI = 1'b0;
        wait_cycles(2);
        check_int("reset_start", int'(BIST_START), 0);
        check_int("reset_abort", int'(BIST_ABORT), 0);
        check_int("reset_algo", int'(BIST_ALGO), 0);
        check_int("reset_so", int'(SO), 0);
        TRESET = 1'b0;
        push_exp("reset_status", 20'h0, 20'hFFFFF);
        scan(20'h0, 1'b1);
    endtask

    task automatic test_multi_loop();
        int r0;
        r0 = mon_start_rises;
        eng_base = eng_runs; fail_pat = 16'b010;
        scan(cmd(1'b1, 1'b0, 2'd2, 8'd3), 1'b0);
        wait_cycles(5);
        check_int("multi_algo", int'(BIST_ALGO), 2);
        wait_cycles(60);
        check_int("multi_start_pulses", mon_start_rises - r0, 3);
        push_exp("multi_status", {FC1, 8'd3, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}, 20'hFFFFF);
        scan(20'h0, 1'b1);
    endtask

    task automatic test_loops_zero();
        int r0;
        r0 = mon_start_rises;
        eng_base = eng_runs; fail_pat = 16'b1;
        scan(cmd(1'b1, 1'b0, 2'd3, 8'd0), 1'b0);
        wait_cycles(40);
        check_int("loops0_start_pulses", mon_start_rises - r0, 1);
        push_exp("loops0_status", {FC1, 8'd1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}, 20'hFFFFF);
        scan(20'h0, 1'b1);
    endtask

    task automatic test_timeout();
        int h0, a0;
        eng_en = 1'b0;
        h0 = mon_start_high; a0 = mon_abort;
        scan(cmd(1'b1, 1'b0, 2'd1, 8'd1), 1'b0);
        wait_cycles(30);
        check_int("timeout_start_cycles", mon_start_high - h0, 15);
        check_int("timeout_abort_pulses", mon_abort - a0, 1);
        push_exp("timeout_status", 20'h0004A, 20'hFFFFF);
        scan(20'h0, 1'b1);
        eng_en = 1'b1;
    endtask

    task automatic test_cmd_err_abort();
        int a0;
        eng_base = eng_runs; fail_pat = '0;
        scan(cmd(1'b1, 1'b0, 2'd1, 8'd10), 1'b0);
        scan(cmd(1'b1, 1'b0, 2'd3, 8'd2), 1'b0);
        check_int("cmderr_algo_kept", int'(BIST_ALGO), 1);
        a0 = mon_abort;
        push_exp("cmderr_running", 20'h00051, 20'h000D1);
        scan(cmd(1'b1, 1'b1, 2'd0, 8'd0), 1'b1);
        wait_cycles(3);
        check_int("abort_pulses", mon_abort - a0, 1);
        push_exp("aborted_status", 20'h00072, 20'h000FF);
        scan(20'h0, 1'b1);
    endtask

    task automatic test_coincident();
        int a0;
        done_delay = 15;
        eng_base = eng_runs; fail_pat = '0;
        a0 = mon_abort;
        scan(cmd(1'b1, 1'b0, 2'd0, 8'd1), 1'b0);
        wait_cycles(40);
        check_int("coincident_no_abort", mon_abort - a0, 0);
        push_exp("coincident_status", 20'h00102, 20'hFFFFF);
        scan(20'h0, 1'b1);
        done_delay = 10;
    endtask

    task automatic test_treset_mid_run();
        int a0, n;
        eng_base = eng_runs; fail_pat = '0;
        scan(cmd(1'b1, 1'b0, 2'd2, 8'd5), 1'b0);
        n = 0;
        while (!BIST_BUSY && n < 20) begin
            @(negedge TCLK);
            n++;
        end
        checks++;
        if (!BIST_BUSY) begin
            errors++;
            $display("FAIL treset_busy_wait: got busy %b expected 1 within 20 cycles", BIST_BUSY);
        end
        wait_cycles(3);
        a0 = mon_abort;
        #2 TRESET = 1'b1;
        #1;
        check_int("treset_start", int'(BIST_START), 0);
        check_int("treset_abort", int'(BIST_ABORT), 0);
        check_int("treset_algo", int'(BIST_ALGO), 0);
        check_int("treset_so", int'(SO), 0);
        wait_cycles(2);
        TRESET = 1'b0;
        wait_cycles(3);
        check_int("treset_no_abort", mon_abort - a0, 0);
        push_exp("treset_status", 20'h0, 20'hFFFFF);
        scan(20'h0, 1'b1);
    endtask

    task automatic test_enable_gate();
        int r0;
        logic [19:0] c;
        c = cmd(1'b1, 1'b0, 2'd1, 8'd1);
        eng_base = eng_runs; fail_pat = '0;
        r0 = mon_start_rises;
        @(negedge TCLK); Enable = 1'b1; ShiftDR = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge TCLK);
            SI = c[i];
        end
        @(negedge TCLK); ShiftDR = 1'b0; Enable = 1'b0; UpdateDR = 1'b1; SI = 1'b0;
        @(negedge TCLK); UpdateDR = 1'b0; CaptureDR = 1'b1;
        @(negedge TCLK); CaptureDR = 1'b0; ShiftDR = 1'b1;
        wait_cycles(5);
        ShiftDR = 1'b0;
        wait_cycles(3);
        check_int("gated_no_start", mon_start_rises - r0, 0);
        Enable = 1'b1; UpdateDR = 1'b1;
        @(negedge TCLK); UpdateDR = 1'b0;
        wait_cycles(3);
        check_int("enabled_start", mon_start_rises - r0, 1);
        wait_cycles(30);
    endtask

    initial begin
        test_reset();
        test_multi_loop();
        test_loops_zero();
        test_timeout();
        test_cmd_err_abort();
        test_coincident();
        test_treset_mid_run();
        test_enable_gate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
